// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART responder.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;
    localparam int CLKS_PER_BIT_DEFAULT = 96;   // 11.0592 MHz / 115200

    // Common state encoding for the TX and RX frame FSMs.
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter. A load of N makes tick_o assert on the Nth cycle
// after the load, so an FSM that reloads on every tick stays in each state
// for exactly N cycles. The counter parks at zero (tick high) when unused.
module uart_bit_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload takes priority, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_responder.sv
// Device side of the CPU serial-port strobe interface: CPU writes go through
// THR/TSR out on txd as 8N1 frames; 8N1 frames on rxd land in RBR.
// Strobe handshake: a write is the sampled wrn falling edge and is accepted
// only while tbre=1 (otherwise dropped); a read completes on the sampled rdn
// rising edge, which releases data_ready and rx_overrun.
module uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrn,
    input  logic                 rdn,
    input  logic [DATA_BITS-1:0] data_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_oe,
    output logic                 data_ready,
    output logic                 tbre,
    output logic                 tsre,
    output logic                 rx_overrun,
    output logic                 txd,
    input  logic                 rxd
);

    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  BIT_LOAD  = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    // Strobe history and rxd synchronizer
    logic wrn_q, rdn_q, rxd_meta_q, rxd_s_q;
    logic wr_fall, rd_rise;

    // TX path
    uart_state_t          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] thr_q, thr_d, tsr_q, tsr_d;
    logic                 tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 tx_load, tx_tick;

    // RX path
    uart_state_t          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rbr_q, rbr_d;
    logic                 ready_q, ready_d, overrun_q, overrun_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic                 rx_load, rx_tick, rx_done;
    logic [CW-1:0]        rx_load_val;

    assign wr_fall = ~wrn & wrn_q;
    assign rd_rise = rdn & ~rdn_q;

    uart_bit_timer #(.W(CW)) u_tx_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_val_i (BIT_LOAD),
        .tick_o     (tx_tick)
    );

    uart_bit_timer #(.W(CW)) u_rx_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rx_load),
        .load_val_i (rx_load_val),
        .tick_o     (rx_tick)
    );

    // Strobe edge history and two-flop rxd synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrn_q      <= 1'b1;
            rdn_q      <= 1'b1;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            wrn_q      <= wrn;
            rdn_q      <= rdn;
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // TX next state: THR write, THR->TSR handoff and bit serialisation.
    always_comb begin
        tx_state_d = tx_state_q;
        thr_d      = thr_q;
        tsr_d      = tsr_q;
        tbre_d     = tbre_q;
        tsre_d     = tsre_q;
        txd_d      = txd_q;
        tx_bit_d   = tx_bit_q;
        tx_load    = 1'b0;
        // Accept only into an empty THR; tbre_q=1 excludes a same-cycle handoff.
        if (wr_fall && tbre_q) begin
            thr_d  = data_i;
            tbre_d = 1'b0;
        end
        case (tx_state_q)
            ST_IDLE: begin
                if (!tbre_q) begin
                    tsr_d      = thr_q;
                    tbre_d     = 1'b1;
                    tsre_d     = 1'b0;
                    txd_d      = 1'b0;
                    tx_state_d = ST_START;
                    tx_load    = 1'b1;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    txd_d      = tsr_q[0];
                    tsr_d      = {1'b0, tsr_q[DATA_BITS-1:1]};
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                    tx_load    = 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (tx_bit_q == LAST_BIT) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        txd_d    = tsr_q[0];
                        tsr_d    = {1'b0, tsr_q[DATA_BITS-1:1]};
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            default: begin // ST_STOP
                if (tx_tick) begin
                    if (!tbre_q) begin
                        // Pending byte: chain the next start bit with no idle gap.
                        tsr_d      = thr_q;
                        tbre_d     = 1'b1;
                        txd_d      = 1'b0;
                        tx_state_d = ST_START;
                        tx_load    = 1'b1;
                    end else begin
                        tsre_d     = 1'b1;
                        tx_state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // TX registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            thr_q      <= '0;
            tsr_q      <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
            tx_bit_q   <= 3'd0;
        end else begin
            tx_state_q <= tx_state_d;
            thr_q      <= thr_d;
            tsr_q      <= tsr_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            txd_q      <= txd_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    // RX next state: mid-bit sampling, RBR update and read release.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rbr_d       = rbr_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        rx_load     = 1'b0;
        rx_load_val = BIT_LOAD;
        rx_done     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rxd_s_q) begin
                    rx_state_d  = ST_START;
                    rx_load     = 1'b1;
                    rx_load_val = HALF_LOAD;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (!rxd_s_q) begin
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_DATA;
                        rx_load    = 1'b1;
                    end else begin
                        rx_state_d = ST_IDLE;   // glitch, not a start bit
                    end
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rxd_s_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            default: begin // ST_STOP
                if (rx_tick) begin
                    rx_state_d = ST_IDLE;
                    rx_done    = rxd_s_q;   // framing error drops the byte silently
                end
            end
        endcase
        // A byte landing on the same cycle as a read wins, but the read still
        // clears the overrun flag.
        if (rx_done) begin
            rbr_d     = rx_shift_q;
            ready_d   = 1'b1;
            overrun_d = rd_rise ? 1'b0 : (overrun_q | ready_q);
        end else if (rd_rise) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // RX registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= 3'd0;
            rbr_q      <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rbr_q      <= rbr_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_o     = rbr_q;
    assign data_oe    = ~rdn;
    assign data_ready = ready_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign rx_overrun = overrun_q;
    assign txd        = txd_q;

endmodule

// File: tb/tb_uart_responder.sv
// Bench for uart_responder with CLKS_PER_BIT=4: CPU strobe drivers, a txd
// frame decoder fed by an expected-byte queue, and an rxd frame driver.
module tb_uart_responder;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_ready;
    } rx_vec_t;

    logic       clk = 1'b0;
    logic       rst, wrn, rdn, rxd;
    logic [7:0] data_i, data_o;
    logic       data_oe, data_ready, tbre, tsre, rx_overrun, txd;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       mon_en = 1'b0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    uart_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .wrn        (wrn),
        .rdn        (rdn),
        .data_i     (data_i),
        .data_o     (data_o),
        .data_oe    (data_oe),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rx_overrun (rx_overrun),
        .txd        (txd),
        .rxd        (rxd)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] d);
        @(negedge clk);
        wrn    = 1'b0;
        data_i = d;
        @(negedge clk);
        wrn    = 1'b1;
    endtask

    task automatic cpu_read();
        @(negedge clk);
        rdn = 1'b0;
        #1;
        check("rd_data_oe_on", data_oe, 1'b1);
        idle(2);
        rdn = 1'b1;
        @(negedge clk);
        check("rd_data_oe_off", data_oe, 1'b0);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_tbre();
        for (int i = 0; i < 400; i++) begin
            if (tbre === 1'b1) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL tbre_timeout: got 0x%0h expected 0x1", tbre);
    endtask

    task automatic wait_tsre();
        for (int i = 0; i < 400; i++) begin
            if (tsre === 1'b1) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL tsre_timeout: got 0x%0h expected 0x1", tsre);
    endtask

    // ---------------- scoreboard: txd frame decoder ----------------
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_bit", txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", txd, 1'b1);
                if (tx_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h expected none", b);
                end else begin
                    e = tx_exp_q.pop_front();
                    check("tx_frame_data", b, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rx_vec_t    rx_tbl[8];
        logic [7:0] tx_tbl[5];
        logic [9:0] frame;
        logic [7:0] e;
        logic [7:0] last_good;
        int         t0;

        rx_tbl[0] = '{8'h3C, 1'b1, 1'b1};
        rx_tbl[1] = '{8'h81, 1'b0, 1'b0};
        rx_tbl[2] = '{8'hA5, 1'b1, 1'b1};
        rx_tbl[3] = '{8'h00, 1'b1, 1'b1};
        rx_tbl[4] = '{8'hFF, 1'b1, 1'b1};
        rx_tbl[5] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1};
        rx_tbl[6] = '{8'($urandom_range(0, 255)), 1'b0, 1'b0};
        rx_tbl[7] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1};
        tx_tbl[0] = 8'h00;
        tx_tbl[1] = 8'hFF;
        tx_tbl[2] = 8'h3C;
        tx_tbl[3] = 8'($urandom_range(0, 255));
        tx_tbl[4] = 8'($urandom_range(0, 255));

        rst = 1'b1; wrn = 1'b1; rdn = 1'b1; rxd = 1'b1; data_i = 8'h00;
        idle(3);
        check("rst_txd", txd, 1'b1);
        check("rst_tbre", tbre, 1'b1);
        check("rst_tsre", tsre, 1'b1);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_data_o", data_o, 8'h00);
        check("rst_overrun", rx_overrun, 1'b0);
        check("rst_data_oe", data_oe, 1'b0);
        rst = 1'b0;
        idle(2);
        mon_en = 1'b1;

        // Single TX 0xA5: exact per-cycle bit sequence and frame length.
        tx_exp_q.push_back(8'hA5);
        cpu_write(8'hA5);
        t0 = cyc;
        check("wr_tbre_low", tbre, 1'b0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check("tx_a5_bit", txd, frame[i]);
                if (i == 0 && c == 0) begin
                    check("tx_load_tbre", tbre, 1'b1);
                    check("tx_load_tsre", tsre, 1'b0);
                end
            end
        end
        wait_tsre();
        check("tx_a5_len", cyc - t0, 41);
        check("tx_a5_idle_txd", txd, 1'b1);

        // Back-to-back: 0x55 then 0x0F chained, 0xFF dropped while THR full.
        idle(4);
        tx_exp_q.push_back(8'h55);
        cpu_write(8'h55);
        t0 = cyc;
        wait_tbre();
        tx_exp_q.push_back(8'h0F);
        cpu_write(8'h0F);
        check("b2b_thr_full", tbre, 1'b0);
        cpu_write(8'hFF);
        check("b2b_drop_tbre", tbre, 1'b0);
        wait_tsre();
        check("b2b_len", cyc - t0, 81);
        idle(4);
        check("b2b_queue_drained", tx_exp_q.size(), 0);

        // TX table: stream of writes, each issued once THR is free.
        for (int i = 0; i < 5; i++) begin
            wait_tbre();
            tx_exp_q.push_back(tx_tbl[i]);
            cpu_write(tx_tbl[i]);
        end
        idle(2);
        wait_tsre();
        idle(4);
        check("tx_tbl_queue_drained", tx_exp_q.size(), 0);

        // RX table: good frames are read back, bad-stop frames leave RBR alone.
        last_good = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (rx_tbl[i].exp_ready) rx_exp_q.push_back(rx_tbl[i].data);
            send_rx(rx_tbl[i].data, rx_tbl[i].stop_bit);
            idle(6);
            check("rx_data_ready", data_ready, rx_tbl[i].exp_ready);
            check("rx_overrun_clear", rx_overrun, 1'b0);
            if (rx_tbl[i].exp_ready) begin
                e = rx_exp_q.pop_front();
                check("rx_data_o", data_o, e);
                last_good = e;
                cpu_read();
                check("rx_read_release", data_ready, 1'b0);
            end else begin
                check("rx_reject_keep", data_o, last_good);
            end
        end

        // One-cycle glitch on rxd must not start a reception.
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        idle(50);
        check("glitch_no_ready", data_ready, 1'b0);
        check("glitch_keep_data", data_o, last_good);

        // Overrun: two bytes without a read, then one read clears both flags.
        send_rx(8'h11, 1'b1);
        idle(6);
        check("ovr_first_ready", data_ready, 1'b1);
        check("ovr_first_flag", rx_overrun, 1'b0);
        check("ovr_first_data", data_o, 8'h11);
        send_rx(8'h22, 1'b1);
        idle(6);
        check("ovr_second_data", data_o, 8'h22);
        check("ovr_second_flag", rx_overrun, 1'b1);
        check("ovr_second_ready", data_ready, 1'b1);
        cpu_read();
        check("ovr_read_ready", data_ready, 1'b0);
        check("ovr_read_flag", rx_overrun, 1'b0);

        // Reset mid-TX with an unread RX byte pending.
        send_rx(8'h77, 1'b1);
        idle(6);
        check("mid_rst_pre_data", data_o, 8'h77);
        mon_en = 1'b0;
        cpu_write(8'h5A);
        idle(10);
        check("mid_rst_pre_tsre", tsre, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_txd_next", txd, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_tbre", tbre, 1'b1);
        check("mid_rst_tsre", tsre, 1'b1);
        check("mid_rst_ready", data_ready, 1'b0);
        check("mid_rst_data_o", data_o, 8'h00);
        check("mid_rst_overrun", rx_overrun, 1'b0);
        idle(20);
        check("post_rst_txd_idle", txd, 1'b1);
        check("post_rst_tsre_idle", tsre, 1'b1);

        // ---------------- final report ----------------
        check("rx_queue_empty", rx_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
